// File: rtl/i_ref_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// i_ref_sweep_ctrl
//
// Sweeps the current reference i_ref upward from I_START in I_STEP
// increments. Each step waits SETTLE_CYCLES clocks, then gives one ready
// pulse so the downstream sampling stage can take a measurement, then takes
// one clock to advance the code. A deglitched instability indicator aborts
// the sweep to a safe i_ref (I_START) and raises went_unstable until the
// sweep is disabled. When the next step would overflow the bus, the sweep
// stops with done held and i_ref left at the last applied code.
//
// Ports
//   clk            in   1          clock
//   rst            in   1          asynchronous, active-high reset
//   enable         in   1          level: 1 = run sweep, 0 = abort to IDLE
//   unstable_in    in   1          synchronous raw instability indicator
//   i_ref          out  BUS_WIDTH  applied current reference (registered)
//   ready          out  1          1-cycle pulse: current i_ref settled
//   went_unstable  out  1          instability confirmed, held until enable=0
//   done           out  1          sweep reached top code without instability
//   busy           out  1          high while in SETTLE / SAMPLE / STEP
//
// All outputs are registered and decoded from the next state, so each flag
// lines up with the state the FSM enters on the same edge.
// ---------------------------------------------------------------------------
module i_ref_sweep_ctrl #(
  parameter int BUS_WIDTH     = 10,
  parameter int I_START       = 0,
  parameter int I_STEP        = 4,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_W         = 16,
  parameter int DEGLITCH      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 unstable_in,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 ready,
  output logic                 went_unstable,
  output logic                 done,
  output logic                 busy
);

  localparam int DG_W = (DEGLITCH < 1) ? 1 : $clog2(DEGLITCH + 1);

  localparam logic [BUS_WIDTH-1:0] START_CODE  = BUS_WIDTH'(I_START);
  localparam logic [BUS_WIDTH:0]   STEP_EXT    = (BUS_WIDTH + 1)'(I_STEP);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DG_W-1:0]      DG_MAX      = DG_W'(DEGLITCH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_UNSTABLE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]     settle_cnt, settle_nxt;
  logic [DG_W-1:0]      deg_cnt, deg_nxt, deg_inc;
  logic [BUS_WIDTH:0]   step_sum;
  logic                 step_ovf;
  logic                 sweep_active;
  logic                 deg_hit;
  logic                 settle_end;

  logic [BUS_WIDTH-1:0] i_ref_nxt;
  logic                 ready_nxt;
  logic                 went_unstable_nxt;
  logic                 done_nxt;
  logic                 busy_nxt;

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------

  // Next code computed one bit wider so the top-code check cannot wrap.
  assign step_sum = {1'b0, i_ref} + STEP_EXT;
  assign step_ovf = step_sum[BUS_WIDTH];

  assign sweep_active = (state == S_SETTLE) || (state == S_SAMPLE) ||
                        (state == S_STEP);

  assign settle_end = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);

  // Saturating increment of the deglitch count.
  assign deg_inc = (deg_cnt == DG_MAX) ? DG_MAX : deg_cnt + DG_W'(1);

  // The count that would be registered this cycle reaches the threshold:
  // the FSM leaves for UNSTABLE on this very edge, ahead of any normal
  // transition (settle end, sample, step).
  assign deg_hit = sweep_active && unstable_in && (deg_inc == DG_MAX);

  // -------------------------------------------------------------------------
  // Process 1: state and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      deg_cnt       <= '0;
      i_ref         <= START_CODE;
      ready         <= 1'b0;
      went_unstable <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      settle_cnt    <= settle_nxt;
      deg_cnt       <= deg_nxt;
      i_ref         <= i_ref_nxt;
      ready         <= ready_nxt;
      went_unstable <= went_unstable_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;

    if (!enable) begin
      state_nxt = S_IDLE;
    end else if (deg_hit) begin
      state_nxt = S_UNSTABLE;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_SETTLE;
        S_SETTLE:   state_nxt = settle_end ? S_SAMPLE : S_SETTLE;
        S_SAMPLE:   state_nxt = S_STEP;
        S_STEP:     state_nxt = step_ovf ? S_DONE : S_SETTLE;
        S_UNSTABLE: state_nxt = S_UNSTABLE;
        S_DONE:     state_nxt = S_DONE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // Settle counter restarts on every entry into SETTLE.
    settle_nxt = '0;
    if ((state == S_SETTLE) && (state_nxt == S_SETTLE)) begin
      settle_nxt = settle_cnt + CNT_W'(1);
    end

    // Deglitch counter runs across SETTLE/SAMPLE/STEP and is cleared by any
    // stable cycle or by leaving the active sweep states.
    deg_nxt = '0;
    if (sweep_active && unstable_in &&
        ((state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE) ||
         (state_nxt == S_STEP))) begin
      deg_nxt = deg_inc;
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    i_ref_nxt         = i_ref;
    ready_nxt         = 1'b0;
    went_unstable_nxt = 1'b0;
    done_nxt          = 1'b0;
    busy_nxt          = 1'b0;

    case (state_nxt)
      S_IDLE: begin
        i_ref_nxt = START_CODE;
      end
      S_SETTLE: begin
        busy_nxt = 1'b1;
        // The code only advances when STEP hands back to SETTLE.
        if (state == S_STEP) begin
          i_ref_nxt = step_sum[BUS_WIDTH-1:0];
        end
      end
      S_SAMPLE: begin
        busy_nxt  = 1'b1;
        ready_nxt = 1'b1;
      end
      S_STEP: begin
        busy_nxt = 1'b1;
      end
      S_UNSTABLE: begin
        i_ref_nxt         = START_CODE;
        went_unstable_nxt = 1'b1;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        i_ref_nxt = START_CODE;
      end
    endcase
  end

endmodule

// File: tb/tb_i_ref_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i_ref_sweep_ctrl
//
// Directed bench for i_ref_sweep_ctrl with BUS_WIDTH=4, I_START=0, I_STEP=4,
// SETTLE_CYCLES=4, DEGLITCH=3.
//
// Hand-derived timeline after enable rises (edge 0 is the first clock edge
// with enable=1, outputs sampled 1 time unit after each edge):
//   edge 0        IDLE -> SETTLE, busy=1, i_ref=0
//   edges 4,10,.. ready pulse (SAMPLE), one every 6 edges
//   edges 6,12,18 i_ref advances to 4, 8, 12
//   edge 24       STEP at i_ref=12 -> DONE (12+4 = 16 > 15), busy=0
// Once instability is confirmed at edge F: went_unstable=1, i_ref=0, all
// other flags 0, for every later edge.
// ---------------------------------------------------------------------------
module tb_i_ref_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       unstable_in;
  logic [3:0] i_ref;
  logic       ready;
  logic       went_unstable;
  logic       done;
  logic       busy;

  int n_assert;
  int n_fail;

  i_ref_sweep_ctrl #(
    .BUS_WIDTH    (4),
    .I_START      (0),
    .I_STEP       (4),
    .SETTLE_CYCLES(4),
    .CNT_W        (16),
    .DEGLITCH     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .unstable_in  (unstable_in),
    .i_ref        (i_ref),
    .ready        (ready),
    .went_unstable(went_unstable),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_iref,
                            input logic e_rdy, input logic e_wu,
                            input logic e_done, input logic e_busy);
    check({tag, ".i_ref"},         32'(i_ref),         32'(e_iref));
    check({tag, ".ready"},         32'(ready),         32'(e_rdy));
    check({tag, ".went_unstable"}, 32'(went_unstable), 32'(e_wu));
    check({tag, ".done"},          32'(done),          32'(e_done));
    check({tag, ".busy"},          32'(busy),          32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after edge k of a sweep (timeline in file header).
  // fail_edge = 0 means no instability is confirmed.
  task automatic model(input int k, input int fail_edge,
                       output logic [3:0] e_iref, output logic e_rdy,
                       output logic e_wu, output logic e_done,
                       output logic e_busy);
    if (fail_edge > 0 && k >= fail_edge) begin
      e_iref = 4'd0;
      e_rdy  = 1'b0;
      e_wu   = 1'b1;
      e_done = 1'b0;
      e_busy = 1'b0;
    end else begin
      e_iref = (k >= 18) ? 4'd12 : 4'(4 * (k / 6));
      e_rdy  = (k < 24) && ((k % 6) == 4);
      e_wu   = 1'b0;
      e_done = (k >= 24);
      e_busy = (k < 24);
    end
  endtask

  // Raise enable and step through edges 0..last_k, driving unstable_in high
  // for the cycles that end on edges unst_lo..unst_hi.
  task automatic run_sweep(input string tag, input int unst_lo,
                           input int unst_hi, input int fail_edge,
                           input int last_k);
    logic [3:0] e_iref;
    logic       e_rdy, e_wu, e_done, e_busy;
    enable = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      unstable_in = (k >= unst_lo) && (k <= unst_hi);
      tick();
      model(k, fail_edge, e_iref, e_rdy, e_wu, e_done, e_busy);
      check_outs($sformatf("%s.e%0d", tag, k), e_iref, e_rdy, e_wu,
                 e_done, e_busy);
    end
    unstable_in = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    unstable_in = 1'b0;
    enable      = 1'b0;
    tick();
    check_outs(tag, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    enable      = 1'b0;
    unstable_in = 1'b0;

    // 1. Reset state, then enable held low.
    #2;
    check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #15;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((i % 5) == 4) check_outs($sformatf("idle%0d", i), 4'd0, 1'b0,
                                   1'b0, 1'b0, 1'b0);
    end

    // 2. Clean sweep to the top code, then DONE held.
    run_sweep("sweep", -1, -2, 0, 32);
    go_idle("sweep.off");

    // 3. Three unstable cycles in SETTLE at i_ref=8 -> UNSTABLE at edge 15.
    run_sweep("unst3", 13, 15, 15, 30);
    go_idle("unst3.off");

    // 4. Two unstable cycles only -> ignored, sweep completes.
    run_sweep("glitch2", 13, 14, 0, 30);
    go_idle("glitch2.off");

    // 5. Count reaches 3 on the last SETTLE cycle (edge 16 would be SAMPLE).
    run_sweep("lastset", 14, 16, 16, 24);
    go_idle("lastset.off");

    // 5b. Instability straddling SAMPLE/STEP at i_ref=0: edges 4,5,6 -> 6.
    run_sweep("straddle", 4, 6, 6, 12);
    go_idle("straddle.off");

    // 6. Drop enable mid-SETTLE at i_ref=4.
    run_sweep("abort", -1, -2, 0, 7);
    go_idle("abort.off");

    // Async reset mid-SETTLE at i_ref=4, then restart from the bottom.
    run_sweep("prerst", -1, -2, 0, 8);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    run_sweep("restart", -1, -2, 0, 26);
    go_idle("restart.off");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
